// File: rtl/reader_pie_pkg.sv
// Shared definitions for the reader-side PIE command transmitter:
// FSM state encoding and symbol-length helpers.
package reader_pie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_SYNC0,
    ST_RTCAL,
    ST_TRCAL,
    ST_BITS,
    ST_DONE
  } state_t;

  // Length of a PIE data symbol: data-0 is one Tari, data-1 is two Tari.
  function automatic int unsigned bit_sym_len(input logic bit_val, input int unsigned tari);
    return bit_val ? 2 * tari : tari;
  endfunction

  // Largest of three lengths, used to size the symbol counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// Times a single PIE symbol: after load(len, pw) the level output is high
// for len-pw cycles and then low for pw cycles; sym_done marks the last
// cycle so the controller can load the next symbol back-to-back.
// While no symbol is active the level rests high (carrier on).
module pie_symbol_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] pw,
  output logic             level,
  output logic             sym_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] pw_q;
  logic             active_q;

  // Count down from len-1 to 0; a load always wins so symbols chain without gaps.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      pw_q     <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= len - CNT_W'(1);
      pw_q     <= pw;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  // The last pw counts of a symbol form the low pulse.
  assign level    = !active_q || (cnt_q >= pw_q);
  assign sym_done = active_q && (cnt_q == '0);

endmodule

// File: rtl/reader_pie_tx.sv
// Reader-side PIE command transmitter. Serialises a command bit-vector
// (MSB first) into the carrier envelope: delimiter, data-0, RTcal,
// optional TRcal (Query preamble), then one PIE symbol per command bit.
// Requires MAX_BITS >= 2 and 0 < PW_CYC < TARI_CYC.
// Optional build macro READER_PIE_ABORT_EN adds an `abort` input that
// drops an in-flight frame back to idle without a done pulse.
module reader_pie_tx
  import reader_pie_pkg::*;
#(
  parameter int TARI_CYC  = 8,
  parameter int PW_CYC    = 4,
  parameter int DELIM_CYC = 4,
  parameter int TRCAL_CYC = 32,
  parameter int MAX_BITS  = 32,
  localparam int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MAX_BITS-1:0] cmd_bits,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_query,
  output logic                demod_out,
  output logic                busy,
  output logic                done
`ifdef READER_PIE_ABORT_EN
  ,
  input  logic                abort
`endif
);

  localparam int unsigned MAX_SYM = max3(3 * TARI_CYC, TRCAL_CYC, DELIM_CYC);
  localparam int CNT_W = $clog2(MAX_SYM + 1);

  localparam logic [CNT_W-1:0] L_DELIM = CNT_W'(DELIM_CYC);
  localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(bit_sym_len(1'b0, TARI_CYC));
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(bit_sym_len(1'b1, TARI_CYC));
  localparam logic [CNT_W-1:0] L_RTCAL = CNT_W'(3 * TARI_CYC);
  localparam logic [CNT_W-1:0] L_TRCAL = CNT_W'(TRCAL_CYC);
  localparam logic [CNT_W-1:0] L_PW    = CNT_W'(PW_CYC);

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] shift_q;
  logic [LEN_W-1:0]    bit_cnt_q;
  logic                query_q;

  logic                accept;
  logic                shift_en;
  logic                load;
  logic [CNT_W-1:0]    load_len;
  logic [CNT_W-1:0]    load_pw;
  logic                level;
  logic                sym_done;
  logic [LEN_W-1:0]    len_clamped;

  assign len_clamped = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;

  pie_symbol_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .len      (load_len),
    .pw       (load_pw),
    .level    (level),
    .sym_done (sym_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; each symbol's last cycle loads the following symbol.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    load_len = L_ZERO;
    load_pw  = L_PW;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          load     = 1'b1;
          load_len = L_DELIM;
          load_pw  = L_DELIM;
          state_d  = ST_DELIM;
        end
      end
      ST_DELIM: begin
        if (sym_done) begin
          load     = 1'b1;
          load_len = L_ZERO;
          state_d  = ST_SYNC0;
        end
      end
      ST_SYNC0: begin
        if (sym_done) begin
          load     = 1'b1;
          load_len = L_RTCAL;
          state_d  = ST_RTCAL;
        end
      end
      ST_RTCAL: begin
        if (sym_done) begin
          if (query_q) begin
            load     = 1'b1;
            load_len = L_TRCAL;
            state_d  = ST_TRCAL;
          end else if (bit_cnt_q != '0) begin
            load     = 1'b1;
            load_len = shift_q[MAX_BITS-1] ? L_ONE : L_ZERO;
            state_d  = ST_BITS;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_TRCAL: begin
        if (sym_done) begin
          if (bit_cnt_q != '0) begin
            load     = 1'b1;
            load_len = shift_q[MAX_BITS-1] ? L_ONE : L_ZERO;
            state_d  = ST_BITS;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_BITS: begin
        if (sym_done) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LEN_W'(1)) begin
            state_d  = ST_DONE;
          end else begin
            load     = 1'b1;
            load_len = shift_q[MAX_BITS-2] ? L_ONE : L_ZERO;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef READER_PIE_ABORT_EN
    if (abort && busy) begin
      state_d  = ST_IDLE;
      load     = 1'b0;
      shift_en = 1'b0;
    end
`endif
  end

  // Command buffer: latched on acceptance, shifted MSB-first per data symbol.
  // NOTE: the shift register is a plain flop vector, so it is cleared on
  // reset like any other state; only true RAM arrays are left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      query_q   <= 1'b0;
    end else if (accept) begin
      shift_q   <= cmd_bits;
      bit_cnt_q <= len_clamped;
      query_q   <= cmd_query;
    end else if (shift_en) begin
      shift_q   <= {shift_q[MAX_BITS-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q - LEN_W'(1);
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign demod_out = busy ? level : 1'b1;

endmodule

// File: tb/tb_reader_pie_tx.sv
// Self-checking bench for reader_pie_tx. A reference model expands each
// command into the expected per-cycle envelope and pushes it into a queue;
// a monitor pops and compares on every cycle the DUT is busy or done.
// Build with READER_PIE_ABORT_EN to also exercise the abort input.
module tb_reader_pie_tx;

  localparam int TARI  = 8;
  localparam int PW    = 4;
  localparam int DELIM = 4;
  localparam int TRCAL = 32;
  localparam int MAXB  = 32;
  localparam int LEN_W = $clog2(MAXB + 1);
  localparam int LIMIT = 2000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [MAXB-1:0]  cmd_bits = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_query = 1'b0;
  logic             cmd_ready;
  logic             demod_out;
  logic             busy;
  logic             done;
`ifdef READER_PIE_ABORT_EN
  logic             abort = 1'b0;
`endif

  typedef struct packed {
    logic demod;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  reader_pie_tx #(
    .TARI_CYC (TARI),
    .PW_CYC   (PW),
    .DELIM_CYC(DELIM),
    .TRCAL_CYC(TRCAL),
    .MAX_BITS (MAXB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_bits (cmd_bits),
    .cmd_len  (cmd_len),
    .cmd_query(cmd_query),
    .demod_out(demod_out),
    .busy     (busy),
    .done     (done)
`ifdef READER_PIE_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a symbol of length len is high for len-pw cycles then low for pw.
  function automatic void push_sym(input int len, input int pw);
    for (int i = 0; i < len; i++) exp_q.push_back('{demod: (i < len - pw), done: 1'b0});
  endfunction

  function automatic void model_frame(input logic [MAXB-1:0] bits, input int len,
                                      input logic query);
    int n;
    logic [MAXB-1:0] b;
    n = (len > MAXB) ? MAXB : len;
    b = bits;
    push_sym(DELIM, DELIM);
    push_sym(TARI, PW);
    push_sym(3 * TARI, PW);
    if (query) push_sym(TRCAL, PW);
    for (int i = 0; i < n; i++) push_sym(b[MAXB-1-i] ? 2 * TARI : TARI, PW);
    exp_q.push_back('{demod: 1'b1, done: 1'b1});
  endfunction

  // Monitor: compares every busy/done cycle against the queue; checks CW when idle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got busy=%b done=%b demod=%b want idle at %0t",
                   busy, done, demod_out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("demod_out", 32'(demod_out), 32'(mon_e.demod));
          check("done", 32'(done), 32'(mon_e.done));
          check("busy", 32'(busy), 32'(!mon_e.done));
          check("cmd_ready_active", 32'(cmd_ready), 32'd0);
        end
      end else begin
        check("idle_demod", 32'(demod_out), 32'd1);
        if (prev_done) check("ready_after_done", 32'(cmd_ready), 32'd1);
      end
      prev_done = done;
    end
  end

  task automatic start_cmd(input logic [MAXB-1:0] bits, input int len, input logic query,
                           input bit hold, input int repeats);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_bits  = bits;
    cmd_len   = LEN_W'(len);
    cmd_query = query;
    cmd_valid = 1'b1;
    for (int r = 0; r < repeats; r++) model_frame(bits, len, query);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit noise, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_bits  = $urandom;
        cmd_len   = LEN_W'($urandom_range(0, 40));
        cmd_query = 1'($urandom_range(0, 1));
      end
    end while (!done && n < LIMIT);
    if (!done) check("done_timeout", 32'(done), 32'd1);
    if (drop || noise) cmd_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_demod", 32'(demod_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    // Frame-sync, bits 1,0
    start_cmd(32'h8000_0000, 2, 1'b0, 1'b0, 1);
    wait_done(1'b0, 1'b1);

    // Query preamble, no data
    start_cmd($urandom, 0, 1'b1, 1'b0, 1);
    wait_done(1'b0, 1'b1);

    // Length beyond buffer depth is clamped
    start_cmd($urandom, 40, 1'b0, 1'b0, 1);
    wait_done(1'b0, 1'b1);

    // cmd_valid held through the frame: exactly two back-to-back frames
    start_cmd($urandom, 3, 1'b1, 1'b1, 2);
    wait_done(1'b0, 1'b0);
    wait_done(1'b0, 1'b1);

    // Random commands with cmd_valid/bit noise while busy
    for (int k = 0; k < 12; k++) begin
      start_cmd($urandom, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'b0, 1);
      wait_done(1'b1, 1'b1);
    end

    // Asynchronous reset in the middle of the data bits
    start_cmd(32'hA5A5_F00F, 32, 1'b0, 1'b0, 1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_demod", 32'(demod_out), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_cmd($urandom, 5, 1'b1, 1'b0, 1);
    wait_done(1'b0, 1'b1);

`ifdef READER_PIE_ABORT_EN
    // Abort during RTcal
    start_cmd($urandom, 4, 1'b1, 1'b0, 1);
    repeat (18) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_demod", 32'(demod_out), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    // Abort together with cmd_valid in idle: command still accepted
    abort = 1'b1;
    start_cmd($urandom, 6, 1'b0, 1'b0, 1);
    abort = 1'b0;
    wait_done(1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
